// File: rtl/mont_pkg.sv
// Shared types and radix selection for the Montgomery multiplier.
// MONT_RADIX4_EN selects 2 bits per iteration; otherwise 1 bit per iteration.
package mont_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ADDB,
        S_ADDM,
        S_CSUB,
        S_DONE
    } mont_state_t;

`ifdef MONT_RADIX4_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int RADIX = 1 << D;

    // Iteration count for an N-bit operand; the top derives its counter width from this.
    function automatic int iter_of(input int n);
        return n / D;
    endfunction

endpackage

// File: rtl/mont_digit_mux.sv
// Picks 0, X, 2X or 3X by a digit, zero-extended to accumulator width.
module mont_digit_mux #(
    parameter int W = 8
) (
    input  logic [1:0]   digit,
    input  logic [W-1:0] x,
    input  logic [W+1:0] x2,
    input  logic [W+1:0] x3,
    output logic [W+2:0] y
);

    always_comb begin
        y = '0;
        case (digit)
            2'd0:    y = '0;
            2'd1:    y = (W+3)'(x);
            2'd2:    y = (W+3)'(x2);
            default: y = (W+3)'(x3);
        endcase
    end

endmodule

// File: rtl/montgomery_mul_param.sv
// Iterative Montgomery multiplier: result = A*B*2^-N mod M, one digit of A per iteration.
// Define MONT_RADIX4_EN for radix-4 (ITER=N/2); default build is radix-2 (ITER=N).
module montgomery_mul_param
    import mont_pkg::*;
#(
    parameter int N = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int ITER = iter_of(N);
    localparam int CW   = $clog2(ITER);

    mont_state_t    state, state_nxt;
    logic [N-1:0]   a_sr, b_reg, m_reg;
    logic [N+2:0]   c;
    logic [CW-1:0]  cnt;
    logic [N+2:0]   b_sel, m_sel, sum_m;
    logic [D-1:0]   neg_m0, q;
    logic [N:0]     c_low;
    logic           c_ge_m;
    logic [N-1:0]   c_red;
    logic [N+1:0]   b2_in, b3_in, m2_in, m3_in;

`ifdef MONT_RADIX4_EN
    logic [N+1:0]   b2, b3, m2, m3;
    assign b2_in = b2;
    assign b3_in = b3;
    assign m2_in = m2;
    assign m3_in = m3;
`else
    assign b2_in = '0;
    assign b3_in = '0;
    assign m2_in = '0;
    assign m3_in = '0;
`endif

    // q = C * (-M^-1) mod r; for odd M, -M^-1 mod r reduces to -m0 mod r.
    assign neg_m0 = -m_reg[D-1:0];
    assign q      = c[D-1:0] * neg_m0;

    mont_digit_mux #(.W(N)) u_bmux (
        .digit (2'(a_sr[D-1:0])),
        .x     (b_reg),
        .x2    (b2_in),
        .x3    (b3_in),
        .y     (b_sel)
    );

    mont_digit_mux #(.W(N)) u_mmux (
        .digit (2'(q)),
        .x     (m_reg),
        .x2    (m2_in),
        .x3    (m3_in),
        .y     (m_sel)
    );

    assign sum_m  = c + m_sel;
    // C < 2M on exit from the loop, so N+1 bits cover the compare and subtract.
    assign c_low  = c[N:0];
    assign c_ge_m = c_low >= {1'b0, m_reg};
    assign c_red  = c_ge_m ? N'(c_low - {1'b0, m_reg}) : c[N-1:0];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_PRE;
            S_PRE:  state_nxt = S_ADDB;
            S_ADDB: state_nxt = S_ADDM;
            S_ADDM: state_nxt = (cnt == CW'(ITER - 1)) ? S_CSUB : S_ADDB;
            S_CSUB: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_sr   <= '0;
            b_reg  <= '0;
            m_reg  <= '0;
            c      <= '0;
            cnt    <= '0;
            result <= '0;
`ifdef MONT_RADIX4_EN
            b2     <= '0;
            b3     <= '0;
            m2     <= '0;
            m3     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_sr  <= in_a;
                    b_reg <= in_b;
                    m_reg <= in_m;
                end
                S_PRE: begin
                    c   <= '0;
                    cnt <= '0;
`ifdef MONT_RADIX4_EN
                    b2  <= {b_reg, 1'b0};
                    b3  <= {b_reg, 1'b0} + (N+2)'(b_reg);
                    m2  <= {m_reg, 1'b0};
                    m3  <= {m_reg, 1'b0} + (N+2)'(m_reg);
`endif
                end
                S_ADDB: c <= c + b_sel;
                S_ADDM: begin
                    c    <= sum_m >> D;
                    a_sr <= a_sr >> D;
                    cnt  <= cnt + 1'b1;
                end
                S_CSUB: result <= c_red;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mul_param.sv
// Randomized self-checking bench for montgomery_mul_param at N=8 (either radix build).
module tb_montgomery_mul_param;

    localparam int N = 8;
`ifdef MONT_RADIX4_EN
    localparam int ITER = N / 2;
`else
    localparam int ITER = N;
`endif
    localparam int LAT = 2 * ITER + 3;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] in_a = '0, in_b = '0, in_m = '0;
    logic         busy, done;
    logic [N-1:0] result;

    int n_chk = 0;
    int n_err = 0;

    montgomery_mul_param #(.N(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // A*B*2^-N mod M by halving modulo an odd M, N times.
    function automatic longint ref_mont(input longint a, input longint b, input longint m);
        longint x;
        x = (a * b) % m;
        for (int i = 0; i < N; i++)
            x = (x % 2 == 1) ? (x + m) / 2 : x / 2;
        return x;
    endfunction

    // Entered and left #1 after a rising edge; returns in the done cycle.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m,
                         input bit glitch, output int lat);
        in_a = a; in_b = b; in_m = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        in_a = N'($urandom); in_b = N'($urandom); in_m = N'($urandom);
        while (!done && lat < 200) begin
            start = glitch && (lat == 3 || lat == 8);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    int lat, stray;
    logic [N-1:0] ra, rb, rm;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        do_op(5, 7, 239, 0, lat);
        chk("c1_lat", lat, LAT);
        chk("c1_busy_in_done", busy, 1);
        chk("c1_result", result, 227);
        @(posedge clk); #1;

        do_op(1, 1, 239, 0, lat);
        chk("c2_result", result, 225);
        @(posedge clk); #1;
        do_op(0, 200, 239, 0, lat);
        chk("c2_zero", result, 0);
        @(posedge clk); #1;

        do_op(254, 254, 255, 0, lat);
        chk("c3_result", result, 1);
        @(posedge clk); #1;

        // Starts during busy and in the done cycle must be ignored.
        do_op(5, 7, 239, 1, lat);
        chk("c4_lat", lat, LAT);
        chk("c4_result", result, 227);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("c4_done_start_busy", busy, 0);
        chk("c4_done_start_done", done, 0);
        @(posedge clk); #1;

        // Abort during the first ADDM cycle.
        in_a = 9; in_b = 11; in_m = 239; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        chk("c5_busy", busy, 0);
        chk("c5_done", done, 0);
        chk("c5_result", result, 0);
        @(negedge clk) resetn = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) stray++;
        end
        chk("c5_stray_done", stray, 0);
        do_op(5, 7, 239, 0, lat);
        chk("c5_result_after", result, 227);

        // Back-to-back, then random sweep; each start in the cycle after done.
        for (int i = 0; i < 1000; i++) begin
            rm = N'($urandom_range(1, 127) * 2 + 1);
            ra = N'($urandom_range(0, int'(rm) - 1));
            rb = N'($urandom_range(0, int'(rm) - 1));
            @(posedge clk); #1;
            do_op(ra, rb, rm, 0, lat);
            chk("rnd_lat", lat, LAT);
            chk("rnd_result", result, ref_mont(ra, rb, rm));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
